// File: rtl/wallace_dot_accum.sv
// wallace_dot_accum: groups LEN consecutive 8-bit products into one dot-product sum.
// A finished sum waits on a valid/ready output port while the next group keeps accumulating.
// Only the beat that completes a group is stalled, and only while the previous sum is unread.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   clear      synchronous abort of the group in progress (a pending sum is kept)
//   in_valid   in_prod is valid
//   in_ready   block accepts in_prod this cycle (combinational from out_ready)
//   in_prod    unsigned product from the multiplier
//   out_valid  out_sum holds a finished sum
//   out_ready  consumer accepts out_sum
//   out_sum    finished sum, unsigned, ACC_W bits
//   grp_cnt    products accepted so far in the current group
module wallace_dot_accum #(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic [$clog2(LEN)-1:0]  grp_cnt
);

  localparam int unsigned CntW = $clog2(LEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(LEN - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CntW-1:0]  r_cnt;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_valid;

  logic             w_last;
  logic             w_accept;
  logic             w_complete;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_acc_d;
  logic [CntW-1:0]  w_cnt_d;
  logic [ACC_W-1:0] w_out_sum_d;
  logic             w_out_valid_d;

  assign w_last = (r_cnt == LastCnt);
  // Stall only the completing beat, and only while the held sum cannot leave this cycle.
  assign in_ready   = !(w_last && r_out_valid && !out_ready);
  // clear outranks acceptance: the beat presented alongside it is dropped.
  assign w_accept   = in_valid && in_ready && !clear;
  assign w_complete = w_accept && w_last;
  assign w_sum      = r_acc + ACC_W'(in_prod);

  always_comb begin
    w_acc_d       = r_acc;
    w_cnt_d       = r_cnt;
    w_out_sum_d   = r_out_sum;
    w_out_valid_d = r_out_valid;

    if (r_out_valid && out_ready) begin
      w_out_valid_d = 1'b0;
    end

    if (clear) begin
      w_acc_d = '0;
      w_cnt_d = '0;
    end else if (w_complete) begin
      w_out_sum_d   = w_sum;
      w_out_valid_d = 1'b1;
      w_acc_d       = '0;
      w_cnt_d       = '0;
    end else if (w_accept) begin
      w_acc_d = w_sum;
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_acc       <= w_acc_d;
      r_cnt       <= w_cnt_d;
      r_out_sum   <= w_out_sum_d;
      r_out_valid <= w_out_valid_d;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign grp_cnt   = r_cnt;

endmodule

// File: tb/tb_wallace_dot_accum.sv
// Bench for wallace_dot_accum: directed scenarios with literal expectations, then
// randomized traffic, all checked each cycle against a queue-based model of the group.
module tb_wallace_dot_accum;

  localparam int unsigned LEN   = 4;
  localparam int unsigned ACC_W = 10;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]       in_prod;
  logic [ACC_W-1:0] out_sum;
  logic [1:0]       grp_cnt;

  always #5 clk = ~clk;

  wallace_dot_accum #(.LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .grp_cnt   (grp_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: products of the current group, plus the held sum.
  int grp[$];
  bit m_known = 1'b0;
  bit m_valid = 1'b0;
  int m_sum   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, compare against the model, advance the model,
  // then return just after the rising edge.
  task automatic cycle(input bit r, input bit c, input bit v, input int p, input bit ordy);
    bit m_ready;
    int total;
    @(negedge clk);
    rst       = r;
    clear     = c;
    in_valid  = v;
    in_prod   = 8'(p);
    out_ready = ordy;
    #1;
    m_ready = !((grp.size() == LEN - 1) && m_valid && !ordy);
    if (m_known) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_sum", 32'(out_sum), 32'(m_sum));
      chk("grp_cnt", 32'(grp_cnt), 32'(grp.size()));
    end
    if (r) begin
      grp.delete();
      m_valid = 1'b0;
      m_sum   = 0;
      m_known = 1'b1;
    end else begin
      if (m_valid && ordy) m_valid = 1'b0;
      if (c) begin
        grp.delete();
      end else if (v && m_ready) begin
        if (grp.size() == LEN - 1) begin
          total = p;
          foreach (grp[i]) total += grp[i];
          m_sum   = total % (1 << ACC_W);
          m_valid = 1'b1;
          grp.delete();
        end else begin
          grp.push_back(p);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int p, input bit ordy);
    cycle(1'b0, 1'b0, 1'b1, p, ordy);
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 1'b0, 1'b0, 0, ordy);
  endtask

  int basic_prods[4] = '{15, 225, 0, 6};

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_prod = '0; out_ready = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_sum", 32'(out_sum), 0);
    chk("reset grp_cnt", 32'(grp_cnt), 0);
    chk("reset in_ready", 32'(in_ready), 1);

    // Basic sum.
    foreach (basic_prods[i]) beat(basic_prods[i], 1'b1);
    chk("basic out_valid", 32'(out_valid), 1);
    chk("basic out_sum", 32'(out_sum), 246);
    idle(1'b1);
    chk("basic one-cycle valid", 32'(out_valid), 0);

    // Max value, then two back-to-back groups.
    for (int i = 0; i < 4; i++) beat(225, 1'b1);
    chk("max out_sum", 32'(out_sum), 900);
    idle(1'b1);
    for (int i = 0; i < 8; i++) begin
      beat(225, 1'b1);
      if (i == 3) chk("b2b first sum", 32'(out_sum), 900);
    end
    chk("b2b second valid", 32'(out_valid), 1);
    chk("b2b second sum", 32'(out_sum), 900);
    idle(1'b1);

    // Backpressure.
    for (int i = 1; i <= 4; i++) beat(i, 1'b0);
    chk("bp first sum", 32'(out_sum), 10);
    for (int i = 0; i < 3; i++) beat(5, 1'b0);
    chk("bp grp_cnt", 32'(grp_cnt), 3);
    beat(5, 1'b0);
    chk("bp in_ready low", 32'(in_ready), 0);
    chk("bp sum held", 32'(out_sum), 10);
    chk("bp grp_cnt held", 32'(grp_cnt), 3);
    beat(5, 1'b1);
    chk("bp second valid", 32'(out_valid), 1);
    chk("bp second sum", 32'(out_sum), 20);
    chk("bp grp_cnt wrap", 32'(grp_cnt), 0);
    idle(1'b1);

    // Clear drops the partial group and the beat presented with it.
    beat(7, 1'b1);
    beat(7, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 99, 1'b1);
    chk("clear grp_cnt", 32'(grp_cnt), 0);
    for (int i = 0; i < 4; i++) beat(1, 1'b1);
    chk("clear sum", 32'(out_sum), 4);
    idle(1'b1);

    // Reset mid-group.
    for (int i = 0; i < 3; i++) beat(50, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 0, 1'b1);
    chk("rst grp_cnt", 32'(grp_cnt), 0);
    chk("rst out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) beat(2, 1'b1);
    chk("rst next sum", 32'(out_sum), 8);
    idle(1'b1);

    // Randomized traffic: products of two 4-bit operands, sporadic clear and reset.
    for (int n = 0; n < 3000; n++) begin
      bit r, c, v, o;
      int p;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      p = $urandom_range(0, 15) * $urandom_range(0, 15);
      cycle(r, c, v, p, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
